axis_frame_fifo: RTL



---
 rtl/axis_pkg.sv | 17 +
 rtl/axis_fifo_ram.sv | 36 +++
 rtl/axis_frame_fifo.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/axis_pkg.sv
// Shared definitions for the AXI-stream frame FIFO.
//   wr_state_t : write-side frame state (WRITE accepts beats, DROP discards
//                the remainder of a frame that was rejected).
//   ptr_width  : FIFO pointer width for a given address width. The extra
//                MSB distinguishes full from empty.
package axis_pkg;

    typedef enum logic {
        WRITE = 1'b0,
        DROP  = 1'b1
    } wr_state_t;

    function automatic int ptr_width(input int addr_width);
        return addr_width + 1;
    endfunction

endpackage

// File: rtl/axis_fifo_ram.sv
// Simple dual-port RAM: one write port and one synchronous read port.
//   clk       : clock
//   wr_en_i   : write strobe
//   wr_addr_i : write address
//   wr_data_i : write data
//   rd_en_i   : read strobe; rd_data_o updates on the next edge
//   rd_addr_i : read address
//   rd_data_o : registered read data (held when rd_en_i is low)
module axis_fifo_ram #(
    parameter int ADDR_WIDTH = 12,
    parameter int WIDTH      = 10
) (
    input  logic                  clk,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [WIDTH-1:0]      wr_data_i,
    input  logic                  rd_en_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic [WIDTH-1:0]      rd_data_o
);

    logic [WIDTH-1:0] mem_q [2**ADDR_WIDTH];
    logic [WIDTH-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/axis_frame_fifo.sv
// Store-and-forward AXI-stream frame FIFO.
//
// A frame becomes visible at the output only after its tlast beat is
// accepted. Frames marked bad (tuser on tlast) are rolled back, and frames
// that cannot fit are dropped whole.
//
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   input_axis_*        : upstream stream (tdata, tkeep, tvalid, tready, tlast, tuser)
//   output_axis_*       : downstream stream (tdata, tkeep, tvalid, tready, tlast)
//   overflow            : one-cycle pulse, frame dropped for lack of space
//   bad_frame           : one-cycle pulse, frame discarded because tuser=1
//   good_frame          : one-cycle pulse, frame committed
//
// Write state machine:
//   state | meaning
//   WRITE | beats are stored at wr_ptr_cur; tlast commits or rolls back
//   DROP  | rest of a rejected frame is consumed and discarded
module axis_frame_fifo
    import axis_pkg::*;
#(
    parameter int ADDR_WIDTH     = 12,
    parameter int DATA_WIDTH     = 8,
    parameter int KEEP_WIDTH     = DATA_WIDTH / 8,
    parameter int DROP_WHEN_FULL = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] input_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] input_axis_tkeep,
    input  logic                  input_axis_tvalid,
    output logic                  input_axis_tready,
    input  logic                  input_axis_tlast,
    input  logic                  input_axis_tuser,
    output logic [DATA_WIDTH-1:0] output_axis_tdata,
    output logic [KEEP_WIDTH-1:0] output_axis_tkeep,
    output logic                  output_axis_tvalid,
    input  logic                  output_axis_tready,
    output logic                  output_axis_tlast,
    output logic                  overflow,
    output logic                  bad_frame,
    output logic                  good_frame
);

    localparam int               PTR_W   = ptr_width(ADDR_WIDTH);
    localparam int               RAM_W   = DATA_WIDTH + KEEP_WIDTH + 1;
    localparam logic [PTR_W-1:0] DEPTH   = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [PTR_W-1:0] PTR_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic             DWF     = (DROP_WHEN_FULL != 0);

    wr_state_t        state_q, state_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] wr_ptr_cur_q, wr_ptr_cur_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic             overflow_q, overflow_d;
    logic             bad_frame_q, bad_frame_d;
    logic             good_frame_q, good_frame_d;
    logic             mem_valid_q, mem_valid_d;
    logic             out_valid_q, out_valid_d;
    logic [RAM_W-1:0] out_data_q, out_data_d;

    logic             full_cur;
    logic             frame_full;
    logic             empty;
    logic             in_fire;
    logic             ram_we;
    logic             rd_en;
    logic             out_move;
    logic [RAM_W-1:0] ram_rd_data;

    assign full_cur   = (wr_ptr_cur_q - rd_ptr_q) == DEPTH;
    assign frame_full = (wr_ptr_cur_q - wr_ptr_q) == DEPTH;
    assign empty      = (wr_ptr_q == rd_ptr_q);

    // A frame that alone fills the whole RAM can never complete, so the
    // input must keep flowing to let it be dropped instead of deadlocking.
    assign input_axis_tready = ~rst & (~full_cur | DWF | (state_q == DROP) | frame_full);
    assign in_fire           = input_axis_tvalid & input_axis_tready;

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        wr_ptr_cur_d = wr_ptr_cur_q;
        overflow_d   = 1'b0;
        bad_frame_d  = 1'b0;
        good_frame_d = 1'b0;
        ram_we       = 1'b0;
        case (state_q)
            WRITE: begin
                if (in_fire) begin
                    if (full_cur) begin
                        // Only reachable when dropping is allowed; a tlast
                        // beat ends the frame here, so no DROP phase needed.
                        wr_ptr_cur_d = wr_ptr_q;
                        overflow_d   = 1'b1;
                        if (!input_axis_tlast) begin
                            state_d = DROP;
                        end
                    end else begin
                        ram_we       = 1'b1;
                        wr_ptr_cur_d = wr_ptr_cur_q + PTR_ONE;
                        if (input_axis_tlast) begin
                            if (input_axis_tuser) begin
                                wr_ptr_cur_d = wr_ptr_q;
                                bad_frame_d  = 1'b1;
                            end else begin
                                wr_ptr_d     = wr_ptr_cur_q + PTR_ONE;
                                good_frame_d = 1'b1;
                            end
                        end
                    end
                end
            end
            DROP: begin
                if (in_fire && input_axis_tlast) begin
                    state_d = WRITE;
                end
            end
            default: state_d = WRITE;
        endcase
    end

    // Two-stage read pipeline: RAM read register, then output register.
    // The RAM stage may refill whenever its content moves on or it is empty.
    assign out_move = output_axis_tready | ~out_valid_q;
    assign rd_en    = ~empty & (out_move | ~mem_valid_q);

    always_comb begin
        rd_ptr_d    = rd_en ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
        mem_valid_d = rd_en | (mem_valid_q & ~out_move);
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (out_move) begin
            out_valid_d = mem_valid_q;
            if (mem_valid_q) begin
                out_data_d = ram_rd_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= WRITE;
            wr_ptr_q     <= '0;
            wr_ptr_cur_q <= '0;
            rd_ptr_q     <= '0;
            overflow_q   <= 1'b0;
            bad_frame_q  <= 1'b0;
            good_frame_q <= 1'b0;
            mem_valid_q  <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            wr_ptr_cur_q <= wr_ptr_cur_d;
            rd_ptr_q     <= rd_ptr_d;
            overflow_q   <= overflow_d;
            bad_frame_q  <= bad_frame_d;
            good_frame_q <= good_frame_d;
            mem_valid_q  <= mem_valid_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
        end
    end

    axis_fifo_ram #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .WIDTH      (RAM_W)
    ) u_ram (
        .clk       (clk),
        .wr_en_i   (ram_we),
        .wr_addr_i (wr_ptr_cur_q[ADDR_WIDTH-1:0]),
        .wr_data_i ({input_axis_tlast, input_axis_tkeep, input_axis_tdata}),
        .rd_en_i   (rd_en),
        .rd_addr_i (rd_ptr_q[ADDR_WIDTH-1:0]),
        .rd_data_o (ram_rd_data)
    );

    assign output_axis_tvalid = out_valid_q;
    assign output_axis_tlast  = out_data_q[RAM_W-1];
    assign output_axis_tkeep  = out_data_q[DATA_WIDTH +: KEEP_WIDTH];
    assign output_axis_tdata  = out_data_q[DATA_WIDTH-1:0];
    assign overflow           = overflow_q;
    assign bad_frame          = bad_frame_q;
    assign good_frame         = good_frame_q;

endmodule
